// File: rtl/kmeans_centroid_accumulator.sv
// Per-centroid coordinate sum and point-count accumulator for the k-means Top stream.
// On the points-finished marker it drains one record per centroid, then clears for the next iteration.
module kmeans_centroid_accumulator #(
   parameter int K      = 8,
   parameter int DATA_W = 64,
   parameter int SUM_W  = 80,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_in_valid,
   output logic                io_in_ready,
   input  logic                io_in_bits_centeroidsFinished,
   input  logic                io_in_bits_pointsFinished,
   input  logic [15:0]         io_in_bits_centeroidIndex,
   input  logic [DATA_W-1:0]   io_in_bits_point_x,
   input  logic [DATA_W-1:0]   io_in_bits_point_y,
   input  logic [DATA_W-1:0]   io_in_bits_point_z,
   input  logic [3:0]          io_in_tag,
   input  logic                io_out_ready,
   output logic                io_out_valid,
   output logic [15:0]         io_out_bits_centeroidIndex,
   output logic [SUM_W-1:0]    io_out_bits_sum_x,
   output logic [SUM_W-1:0]    io_out_bits_sum_y,
   output logic [SUM_W-1:0]    io_out_bits_sum_z,
   output logic [CNT_W-1:0]    io_out_bits_count,
   output logic                io_out_bits_last,
   output logic [3:0]          io_out_tag,
   output logic [15:0]         io_err_dropped
);

   // state    | meaning
   // ST_ACCUM | accepting point / marker beats, accumulating per centroid
   // ST_DRAIN | presenting records 0..K-1, input stalled

   localparam int          IDX_W    = (K > 1) ? $clog2(K) : 1;
   localparam logic [16:0] K_L      = 17'(K);
   localparam logic [15:0] LAST_IDX = 16'(K - 1);

   typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

   state_t             r_state;
   logic [SUM_W-1:0]   r_sum_x [K];
   logic [SUM_W-1:0]   r_sum_y [K];
   logic [SUM_W-1:0]   r_sum_z [K];
   logic [CNT_W-1:0]   r_cnt   [K];
   logic               r_out_valid;
   logic [15:0]        r_out_idx;
   logic [SUM_W-1:0]   r_out_sum_x;
   logic [SUM_W-1:0]   r_out_sum_y;
   logic [SUM_W-1:0]   r_out_sum_z;
   logic [CNT_W-1:0]   r_out_cnt;
   logic               r_out_last;
   logic [3:0]         r_out_tag;
   logic [15:0]        r_err;

   logic               w_accept;
   logic               w_point;
   logic               w_in_range;
   logic               w_cnt_full;
   logic               w_add;
   logic               w_drop;
   logic [IDX_W-1:0]   w_pidx;
   logic [SUM_W-1:0]   w_ext_x;
   logic [SUM_W-1:0]   w_ext_y;
   logic [SUM_W-1:0]   w_ext_z;
   logic               w_load;
   logic [15:0]        w_ld_idx;
   logic [IDX_W-1:0]   w_ld_sel;

   // Ready is held low while reset is asserted even though the state already reads ACCUM.
   assign io_in_ready = (r_state == ST_ACCUM) && !reset;
   assign w_accept    = io_in_valid && io_in_ready;
   assign w_point     = w_accept && !io_in_bits_pointsFinished && !io_in_bits_centeroidsFinished;
   assign w_pidx      = io_in_bits_centeroidIndex[IDX_W-1:0];
   assign w_in_range  = {1'b0, io_in_bits_centeroidIndex} < K_L;
   assign w_cnt_full  = &r_cnt[w_pidx];
   assign w_add       = w_point && w_in_range && !w_cnt_full;
   assign w_drop      = w_point && !(w_in_range && !w_cnt_full);

   assign w_ext_x = {{(SUM_W-DATA_W){io_in_bits_point_x[DATA_W-1]}}, io_in_bits_point_x};
   assign w_ext_y = {{(SUM_W-DATA_W){io_in_bits_point_y[DATA_W-1]}}, io_in_bits_point_y};
   assign w_ext_z = {{(SUM_W-DATA_W){io_in_bits_point_z[DATA_W-1]}}, io_in_bits_point_z};

   // First record of a drain is loaded while nothing is presented; later ones on acceptance.
   assign w_load   = (r_state == ST_DRAIN) &&
                     (!r_out_valid || (io_out_ready && !r_out_last));
   assign w_ld_idx = r_out_valid ? (r_out_idx + 16'd1) : 16'd0;
   assign w_ld_sel = w_ld_idx[IDX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_ACCUM;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_sum_x <= '0;
         r_out_sum_y <= '0;
         r_out_sum_z <= '0;
         r_out_cnt   <= '0;
         r_out_last  <= 1'b0;
         r_out_tag   <= '0;
         r_err       <= '0;
         for (int i = 0; i < K; i++) begin
            r_sum_x[i] <= '0;
            r_sum_y[i] <= '0;
            r_sum_z[i] <= '0;
            r_cnt[i]   <= '0;
         end
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept && io_in_bits_pointsFinished) begin
                  r_out_tag <= io_in_tag;
                  r_state   <= ST_DRAIN;
               end else if (w_accept && io_in_bits_centeroidsFinished) begin
                  for (int i = 0; i < K; i++) begin
                     r_sum_x[i] <= '0;
                     r_sum_y[i] <= '0;
                     r_sum_z[i] <= '0;
                     r_cnt[i]   <= '0;
                  end
               end else if (w_add) begin
                  r_sum_x[w_pidx] <= r_sum_x[w_pidx] + w_ext_x;
                  r_sum_y[w_pidx] <= r_sum_y[w_pidx] + w_ext_y;
                  r_sum_z[w_pidx] <= r_sum_z[w_pidx] + w_ext_z;
                  r_cnt[w_pidx]   <= r_cnt[w_pidx] + 1'b1;
               end
               if (w_drop && (r_err != 16'hFFFF)) begin
                  r_err <= r_err + 16'd1;
               end
            end
            ST_DRAIN: begin
               if (w_load) begin
                  r_out_valid <= 1'b1;
                  r_out_idx   <= w_ld_idx;
                  r_out_sum_x <= r_sum_x[w_ld_sel];
                  r_out_sum_y <= r_sum_y[w_ld_sel];
                  r_out_sum_z <= r_sum_z[w_ld_sel];
                  r_out_cnt   <= r_cnt[w_ld_sel];
                  r_out_last  <= (w_ld_idx == LAST_IDX);
               end else if (r_out_valid && io_out_ready && r_out_last) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ACCUM;
                  for (int i = 0; i < K; i++) begin
                     r_sum_x[i] <= '0;
                     r_sum_y[i] <= '0;
                     r_sum_z[i] <= '0;
                     r_cnt[i]   <= '0;
                  end
               end
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end

   assign io_out_valid               = r_out_valid;
   assign io_out_bits_centeroidIndex = r_out_idx;
   assign io_out_bits_sum_x          = r_out_sum_x;
   assign io_out_bits_sum_y          = r_out_sum_y;
   assign io_out_bits_sum_z          = r_out_sum_z;
   assign io_out_bits_count          = r_out_cnt;
   assign io_out_bits_last           = r_out_last;
   assign io_out_tag                 = r_out_tag;
   assign io_err_dropped             = r_err;

endmodule
